aip_responder: RTL and testbench

Slave end of the AIP host bus: decodes `conf_dbus`/`write`/`read`/`start` strobes from the host and turns them into core-side memory writes, output-memory reads, configuration words, a start pulse and a masked, active-low interrupt. It sits between the AIP bus pins and a compute core such as the convolution datapath. Register map: input memories X/Y, output memory, a configuration bank, STATUS and IP_ID, each memory with an auto-incrementing pointer.

---
 rtl/aip_pkg.sv | 23 ++
 rtl/aip_status_reg.sv | 70 +++++++
 rtl/aip_responder.sv | 192 +++++++++++++++++++
 tb/tb_aip_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aip_pkg.sv
// Shared definitions for the AIP host-bus responder: register codes and STATUS layout.
package aip_pkg;

    localparam int unsigned DATAWIDTH_DFLT = 32;

    typedef enum logic [4:0] {
        RegMDataInX = 5'd0,
        RegADataInX = 5'd1,
        RegMDataInY = 5'd2,
        RegADataInY = 5'd3,
        RegMDataOut = 5'd4,
        RegADataOut = 5'd5,
        RegDConfig  = 5'd6,
        RegAConfig  = 5'd7,
        RegStatus   = 5'd30,
        RegIpId     = 5'd31
    } aip_reg_e;

    localparam int unsigned MASK_LSB  = 16;
    localparam int unsigned BUSY_BIT  = 8;
    localparam int unsigned FLAGS_LSB = 0;

endpackage

// File: rtl/aip_status_reg.sv
// Interrupt mask, sticky flags, busy bit, start rising-edge detect and the
// registered active-low interrupt request.
module aip_status_reg (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       wr_i,
    input  logic [7:0] mask_i,
    input  logic [7:0] clr_i,
    input  logic       start_i,
    input  logic [7:0] int_set_i,
    output logic [7:0] mask_o,
    output logic [7:0] flags_o,
    output logic       busy_o,
    output logic       core_start_o,
    output logic       int_req_o
);

    logic [7:0] mask_q, mask_d;
    logic [7:0] flags_q, flags_d;
    logic       busy_q, busy_d;
    logic       start_prev_q, start_prev_d;
    logic       core_start_q, core_start_d;
    logic       int_req_q, int_req_d;
    logic       start_rise;
    logic [7:0] set_eff;

    always_comb begin
        start_rise   = en_i & start_i & ~start_prev_q;
        start_prev_d = en_i ? start_i : start_prev_q;
        set_eff      = en_i ? int_set_i : 8'h00;
        mask_d       = wr_i ? mask_i : mask_q;
        // A set pulse wins over a write-1-to-clear of the same bit.
        flags_d      = (flags_q & ~(wr_i ? clr_i : 8'h00)) | set_eff;
        busy_d       = busy_q;
        if (set_eff[0]) begin
            busy_d = 1'b0;
        end
        if (start_rise) begin
            busy_d = 1'b1;
        end
        core_start_d = start_rise;
        int_req_d    = ~|(flags_q & mask_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q       <= '0;
            flags_q      <= '0;
            busy_q       <= 1'b0;
            start_prev_q <= 1'b0;
            core_start_q <= 1'b0;
            int_req_q    <= 1'b1;
        end else begin
            mask_q       <= mask_d;
            flags_q      <= flags_d;
            busy_q       <= busy_d;
            start_prev_q <= start_prev_d;
            core_start_q <= core_start_d;
            int_req_q    <= int_req_d;
        end
    end

    assign mask_o       = mask_q;
    assign flags_o      = flags_q;
    assign busy_o       = busy_q;
    assign core_start_o = core_start_q;
    assign int_req_o    = int_req_q;

endmodule

// File: rtl/aip_responder.sv
// Slave end of the AIP host bus: register decode, auto-incrementing pointers,
// configuration bank and the registered read-data mux.
module aip_responder
    import aip_pkg::*;
#(
    parameter int unsigned          DATAWIDTH  = DATAWIDTH_DFLT,
    parameter int unsigned          ADDR_W     = 6,
    parameter int unsigned          CONF_DEPTH = 4,
    parameter logic [DATAWIDTH-1:0] IP_ID      = 32'h4004_8008
) (
    input  logic                            clk,
    input  logic                            rst_a,
    input  logic                            en_s,
    input  logic [DATAWIDTH-1:0]            data_in,
    output logic [DATAWIDTH-1:0]            data_out,
    input  logic                            write,
    input  logic                            read,
    input  logic                            start,
    input  logic [4:0]                      conf_dbus,
    output logic                            int_req,
    output logic                            memx_we,
    output logic [ADDR_W-1:0]               memx_addr,
    output logic [DATAWIDTH-1:0]            memx_wdata,
    output logic                            memy_we,
    output logic [ADDR_W-1:0]               memy_addr,
    output logic [DATAWIDTH-1:0]            memy_wdata,
    output logic [ADDR_W-1:0]               out_raddr,
    input  logic [DATAWIDTH-1:0]            out_rdata,
    output logic [DATAWIDTH*CONF_DEPTH-1:0] conf_data,
    output logic                            core_start,
    input  logic [7:0]                      int_set
);

    localparam logic [ADDR_W-1:0] PtrOne = ADDR_W'(1);

    logic [ADDR_W-1:0]    ptr_x_q, ptr_x_d, ptr_y_q, ptr_y_d;
    logic [ADDR_W-1:0]    ptr_out_q, ptr_out_d, ptr_conf_q, ptr_conf_d;
    logic [DATAWIDTH-1:0] conf_q [CONF_DEPTH];
    logic [DATAWIDTH-1:0] conf_d [CONF_DEPTH];
    logic [DATAWIDTH-1:0] data_out_q, data_out_d;
    logic                 memx_we_q, memx_we_d, memy_we_q, memy_we_d;
    logic [ADDR_W-1:0]    memx_addr_q, memx_addr_d, memy_addr_q, memy_addr_d;
    logic [DATAWIDTH-1:0] memx_wdata_q, memx_wdata_d, memy_wdata_q, memy_wdata_d;

    logic                 wr_en, rd_en, wr_status;
    logic [DATAWIDTH-1:0] rd_word, status_word, conf_rd;
    logic [7:0]           mask, flags;
    logic                 busy;

    aip_status_reg u_status (
        .clk_i        (clk),
        .rst_ni       (rst_a),
        .en_i         (en_s),
        .wr_i         (wr_status),
        .mask_i       (data_in[MASK_LSB +: 8]),
        .clr_i        (data_in[FLAGS_LSB +: 8]),
        .start_i      (start),
        .int_set_i    (int_set),
        .mask_o       (mask),
        .flags_o      (flags),
        .busy_o       (busy),
        .core_start_o (core_start),
        .int_req_o    (int_req)
    );

    always_comb begin
        // A simultaneous write takes priority; the read is dropped.
        wr_en = en_s & write;
        rd_en = en_s & read & ~write;

        status_word                  = '0;
        status_word[MASK_LSB +: 8]   = mask;
        status_word[BUSY_BIT]        = busy;
        status_word[FLAGS_LSB +: 8]  = flags;

        conf_rd = '0;
        for (int i = 0; i < CONF_DEPTH; i++) begin
            if (ptr_conf_q == ADDR_W'(i)) conf_rd = conf_q[i];
        end

        ptr_x_d      = ptr_x_q;
        ptr_y_d      = ptr_y_q;
        ptr_out_d    = ptr_out_q;
        ptr_conf_d   = ptr_conf_q;
        conf_d       = conf_q;
        memx_we_d    = 1'b0;
        memx_addr_d  = memx_addr_q;
        memx_wdata_d = memx_wdata_q;
        memy_we_d    = 1'b0;
        memy_addr_d  = memy_addr_q;
        memy_wdata_d = memy_wdata_q;
        data_out_d   = data_out_q;
        wr_status    = 1'b0;
        rd_word      = '0;

        if (wr_en) begin
            case (conf_dbus)
                RegMDataInX: begin
                    memx_we_d    = 1'b1;
                    memx_addr_d  = ptr_x_q;
                    memx_wdata_d = data_in;
                    ptr_x_d      = ptr_x_q + PtrOne;
                end
                RegMDataInY: begin
                    memy_we_d    = 1'b1;
                    memy_addr_d  = ptr_y_q;
                    memy_wdata_d = data_in;
                    ptr_y_d      = ptr_y_q + PtrOne;
                end
                RegADataInX: ptr_x_d    = data_in[ADDR_W-1:0];
                RegADataInY: ptr_y_d    = data_in[ADDR_W-1:0];
                RegADataOut: ptr_out_d  = data_in[ADDR_W-1:0];
                RegAConfig:  ptr_conf_d = data_in[ADDR_W-1:0];
                RegDConfig: begin
                    for (int i = 0; i < CONF_DEPTH; i++) begin
                        if (ptr_conf_q == ADDR_W'(i)) conf_d[i] = data_in;
                    end
                    ptr_conf_d = ptr_conf_q + PtrOne;
                end
                RegStatus:   wr_status = 1'b1;
                default: ;
            endcase
        end

        if (rd_en) begin
            case (conf_dbus)
                RegMDataOut: begin
                    rd_word   = out_rdata;
                    ptr_out_d = ptr_out_q + PtrOne;
                end
                RegDConfig: begin
                    rd_word    = conf_rd;
                    ptr_conf_d = ptr_conf_q + PtrOne;
                end
                RegADataInX: rd_word = DATAWIDTH'(ptr_x_q);
                RegADataInY: rd_word = DATAWIDTH'(ptr_y_q);
                RegADataOut: rd_word = DATAWIDTH'(ptr_out_q);
                RegAConfig:  rd_word = DATAWIDTH'(ptr_conf_q);
                RegStatus:   rd_word = status_word;
                RegIpId:     rd_word = IP_ID;
                default:     rd_word = '0;
            endcase
            data_out_d = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            ptr_x_q      <= '0;
            ptr_y_q      <= '0;
            ptr_out_q    <= '0;
            ptr_conf_q   <= '0;
            for (int i = 0; i < CONF_DEPTH; i++) conf_q[i] <= '0;
            memx_we_q    <= 1'b0;
            memx_addr_q  <= '0;
            memx_wdata_q <= '0;
            memy_we_q    <= 1'b0;
            memy_addr_q  <= '0;
            memy_wdata_q <= '0;
            data_out_q   <= '0;
        end else begin
            ptr_x_q      <= ptr_x_d;
            ptr_y_q      <= ptr_y_d;
            ptr_out_q    <= ptr_out_d;
            ptr_conf_q   <= ptr_conf_d;
            conf_q       <= conf_d;
            memx_we_q    <= memx_we_d;
            memx_addr_q  <= memx_addr_d;
            memx_wdata_q <= memx_wdata_d;
            memy_we_q    <= memy_we_d;
            memy_addr_q  <= memy_addr_d;
            memy_wdata_q <= memy_wdata_d;
            data_out_q   <= data_out_d;
        end
    end

    always_comb begin
        for (int i = 0; i < CONF_DEPTH; i++) begin
            conf_data[i*DATAWIDTH +: DATAWIDTH] = conf_q[i];
        end
    end

    assign data_out   = data_out_q;
    assign memx_we    = memx_we_q;
    assign memx_addr  = memx_addr_q;
    assign memx_wdata = memx_wdata_q;
    assign memy_we    = memy_we_q;
    assign memy_addr  = memy_addr_q;
    assign memy_wdata = memy_wdata_q;
    assign out_raddr  = ptr_out_q;

endmodule

// File: tb/tb_aip_responder.sv
// Self-checking bench for aip_responder: directed scenarios with literal
// expectations, then randomized traffic against a register-level model.
module tb_aip_responder;

    logic         clk = 1'b0;
    logic         rst_a = 1'b0;
    logic         en_s = 1'b1;
    logic [31:0]  data_in = '0;
    logic [31:0]  data_out;
    logic         write = 1'b0, read = 1'b0, start = 1'b0;
    logic [4:0]   conf_dbus = '0;
    logic         int_req;
    logic         memx_we, memy_we;
    logic [5:0]   memx_addr, memy_addr, out_raddr;
    logic [31:0]  memx_wdata, memy_wdata, out_rdata;
    logic [127:0] conf_data;
    logic         core_start;
    logic [7:0]   int_set = '0;

    logic [31:0]  outmem [64];
    assign out_rdata = outmem[out_raddr];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    aip_responder dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .en_s       (en_s),
        .data_in    (data_in),
        .data_out   (data_out),
        .write      (write),
        .read       (read),
        .start      (start),
        .conf_dbus  (conf_dbus),
        .int_req    (int_req),
        .memx_we    (memx_we),
        .memx_addr  (memx_addr),
        .memx_wdata (memx_wdata),
        .memy_we    (memy_we),
        .memy_addr  (memy_addr),
        .memy_wdata (memy_wdata),
        .out_raddr  (out_raddr),
        .out_rdata  (out_rdata),
        .conf_data  (conf_data),
        .core_start (core_start),
        .int_set    (int_set)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          px, py, po, pc;
    logic [31:0] conf [4];
    logic [7:0]  mask, flags;
    bit          busy, sprev;
    logic [31:0] e_dout, e_xd, e_yd;
    bit          e_ireq, e_cs, e_xwe, e_ywe;
    int          e_xa, e_ya;

    task automatic model_reset();
        px = 0; py = 0; po = 0; pc = 0;
        for (int i = 0; i < 4; i++) conf[i] = '0;
        mask = '0; flags = '0; busy = 0; sprev = 0;
        e_dout = '0; e_xd = '0; e_yd = '0; e_xa = 0; e_ya = 0;
        e_ireq = 1; e_cs = 0; e_xwe = 0; e_ywe = 0;
    endtask

    task automatic model_step();
        bit          wr, rd;
        logic [7:0]  clr, set;
        logic [31:0] v;
        wr  = en_s && write;
        rd  = en_s && read && !write;
        set = en_s ? int_set : 8'h00;
        clr = 8'h00;
        v   = '0;
        e_ireq = ((flags & mask) == 8'h00);
        e_xwe = 0; e_ywe = 0; e_cs = 0;
        if (rd) begin
            case (int'(conf_dbus))
                4:  begin v = outmem[po]; po = (po + 1) % 64; end
                6:  begin v = (pc < 4) ? conf[pc] : 32'h0; pc = (pc + 1) % 64; end
                1:  v = px;
                3:  v = py;
                5:  v = po;
                7:  v = pc;
                30: v = {8'h00, mask, 7'h00, busy, flags};
                31: v = 32'h4004_8008;
                default: v = 32'h0;
            endcase
            e_dout = v;
        end
        if (wr) begin
            case (int'(conf_dbus))
                0:  begin e_xwe = 1; e_xa = px; e_xd = data_in; px = (px + 1) % 64; end
                2:  begin e_ywe = 1; e_ya = py; e_yd = data_in; py = (py + 1) % 64; end
                1:  px = data_in % 64;
                3:  py = data_in % 64;
                5:  po = data_in % 64;
                7:  pc = data_in % 64;
                6:  begin if (pc < 4) conf[pc] = data_in; pc = (pc + 1) % 64; end
                30: begin mask = data_in[23:16]; clr = data_in[7:0]; end
                default: ;
            endcase
        end
        flags = (flags & ~clr) | set;
        if (set[0]) busy = 0;
        if (en_s && start && !sprev) begin busy = 1; e_cs = 1; end
        if (en_s) sprev = start;
    endtask

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_data_out", data_out, e_dout);
            chk("m_int_req", int_req, e_ireq);
            chk("m_core_start", core_start, e_cs);
            chk("m_memx_we", memx_we, e_xwe);
            chk("m_memx_addr", memx_addr, e_xa[5:0]);
            chk("m_memx_wdata", memx_wdata, e_xd);
            chk("m_memy_we", memy_we, e_ywe);
            chk("m_memy_addr", memy_addr, e_ya[5:0]);
            chk("m_memy_wdata", memy_wdata, e_yd);
            chk("m_out_raddr", out_raddr, po[5:0]);
            chk("m_conf_data", conf_data, {conf[3], conf[2], conf[1], conf[0]});
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic bus(input bit w, input bit r, input logic [4:0] code, input logic [31:0] d);
        write = w; read = r; conf_dbus = code; data_in = d;
        @(negedge clk);
        write = 0; read = 0;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 64; i++) outmem[i] = i * 3;
        model_reset();
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        chk_on = 1'b1;
        chk("rst_data_out", data_out, 0);
        chk("rst_int_req", int_req, 1);
        chk("rst_core_start", core_start, 0);
        chk("rst_conf", conf_data, 0);

        bus(0, 1, 5'd31, 0);
        chk("ip_id", data_out, 32'h4004_8008);
        bus(0, 1, 5'd30, 0);
        chk("status_rst", data_out, 0);
        chk("int_req_idle", int_req, 1);

        bus(1, 0, 5'd1, 0);
        for (int k = 0; k < 5; k++) begin
            bus(1, 0, 5'd0, 32'(11 * (k + 1)));
            chk("x_we", memx_we, 1);
            chk("x_addr", memx_addr, k);
            chk("x_wdata", memx_wdata, 11 * (k + 1));
        end
        bus(0, 1, 5'd1, 0);
        chk("x_ptr", data_out, 5);
        chk("x_we_drop", memx_we, 0);

        bus(1, 0, 5'd3, 63);
        bus(1, 0, 5'd2, 32'hAAAA_0001);
        chk("y_addr63", memy_addr, 63);
        bus(1, 0, 5'd2, 32'hAAAA_0002);
        chk("y_wrap", memy_addr, 0);
        chk("y_wdata", memy_wdata, 32'hAAAA_0002);

        bus(1, 0, 5'd7, 0);
        bus(1, 0, 5'd6, 32'h145);
        chk("conf0", conf_data[31:0], 32'h145);
        cnt = 0;
        start = 1;
        repeat (3) begin @(negedge clk); cnt += core_start; end
        start = 0;
        repeat (2) begin @(negedge clk); cnt += core_start; end
        chk("start_pulses", cnt, 1);
        bus(0, 1, 5'd30, 0);
        chk("busy_set", data_out[8], 1);

        bus(1, 0, 5'd30, 32'h0001_0000);
        int_set = 8'h01;
        @(negedge clk);
        int_set = 8'h00;
        chk("int_req_lag", int_req, 1);
        @(negedge clk);
        chk("int_req_low", int_req, 0);
        bus(0, 1, 5'd30, 0);
        chk("status_int", data_out, 32'h0001_0001);
        bus(1, 0, 5'd30, 32'h0001_0001);
        @(negedge clk);
        chk("int_req_clr", int_req, 1);

        bus(1, 0, 5'd5, 0);
        for (int k = 0; k < 14; k++) begin
            bus(0, 1, 5'd4, 0);
            chk("out_seq", data_out, 3 * k);
        end
        bus(1, 1, 5'd4, 0);
        chk("conflict_hold", data_out, 39);
        chk("conflict_ptr", out_raddr, 14);
        bus(0, 1, 5'd5, 0);
        chk("out_ptr", data_out, 14);

        // Randomized traffic
        for (int i = 0; i < 64; i++) outmem[i] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                write = 1; read = 0; en_s = 1; start = 0; int_set = 0;
                conf_dbus = 5'd0; data_in = $urandom;
                @(negedge clk);
                write = 0;
                #2 rst_a = 1'b0;
                #1;
                chk("async_rst_we", memx_we, 0);
                chk("async_rst_dout", data_out, 0);
                @(negedge clk);
                #2 rst_a = 1'b1;
            end
            en_s  = ($urandom_range(0, 9) != 0);
            write = ($urandom_range(0, 9) < 4);
            read  = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 11))
                8:       conf_dbus = 5'd30;
                9:       conf_dbus = 5'd31;
                10:      conf_dbus = 5'($urandom);
                11:      conf_dbus = 5'd4;
                default: conf_dbus = 5'($urandom_range(0, 7));
            endcase
            data_in = $urandom_range(0, 1) ? 32'($urandom_range(0, 5)) : $urandom;
            if ($urandom_range(0, 3) == 0) start = ~start;
            int_set = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            @(negedge clk);
        end
        write = 0; read = 0; int_set = 0; start = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
